// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: R-type function codes, mult/div op
// encoding and the multicycle controller state type.
package mips_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_WB
   } ctrl_state_e;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_e;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/rtype_funct_decoder.sv
// Combinational R-type function-field decode; all outputs are zero when en=0.
module rtype_funct_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned FUNCT_W = 6
) (
   input  logic               en,
   input  logic [FUNCT_W-1:0] fnctn,
   output logic               rtype,
   output logic               reg_write,
   output logic               reg_write2,
   output logic               jr,
   output logic               muldiv,
   output muldiv_op_e         op
);

   always_comb begin
      rtype      = 1'b0;
      reg_write  = 1'b0;
      reg_write2 = 1'b0;
      jr         = 1'b0;
      muldiv     = 1'b0;
      op         = OP_MULT;
      if (en) begin
         if (fnctn == FUNCT_W'(FN_JR)) begin
            jr = 1'b1;
         end else if (fnctn == FUNCT_W'(FN_MTHI) || fnctn == FUNCT_W'(FN_MTLO)) begin
            reg_write2 = 1'b1;
         end else if (fnctn == FUNCT_W'(FN_MFHI) || fnctn == FUNCT_W'(FN_MFLO)) begin
            reg_write = 1'b1;
         end else if (fnctn == FUNCT_W'(FN_MULT)) begin
            muldiv = 1'b1;
            op     = OP_MULT;
         end else if (fnctn == FUNCT_W'(FN_MULTU)) begin
            muldiv = 1'b1;
            op     = OP_MULTU;
         end else if (fnctn == FUNCT_W'(FN_DIV)) begin
            muldiv = 1'b1;
            op     = OP_DIV;
         end else if (fnctn == FUNCT_W'(FN_DIVU)) begin
            muldiv = 1'b1;
            op     = OP_DIVU;
         end else begin
            rtype     = 1'b1;
            reg_write = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rtype_multicycle_controller.sv
// R-type controller: funct decode plus a stall FSM that holds the pipeline
// for a fixed number of cycles per mult/div and pulses HI/LO write-back.
module rtype_multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32,
   parameter int unsigned FUNCT_W     = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic               rtype_i,
   input  logic [FUNCT_W-1:0] fnctn,
   output logic               rtype,
   output logic               reg_write,
   output logic               reg_write2,
   output logic               jr,
   output logic               muldiv_start,
   output logic [1:0]         muldiv_op,
   output logic               busy
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   ctrl_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   muldiv_op_e       op_q, op_d;

   logic       dec_en;
   logic       d_rtype, d_reg_write, d_reg_write2, d_jr, d_muldiv;
   muldiv_op_e d_op;

   // Decode is suppressed while stalled so held instructions wait for WB/IDLE.
   assign dec_en = valid_i & rtype_i & (state_q != ST_BUSY);

   rtype_funct_decoder #(
      .FUNCT_W (FUNCT_W)
   ) u_dec (
      .en         (dec_en),
      .fnctn      (fnctn),
      .rtype      (d_rtype),
      .reg_write  (d_reg_write),
      .reg_write2 (d_reg_write2),
      .jr         (d_jr),
      .muldiv     (d_muldiv),
      .op         (d_op)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MULT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      rtype        = d_rtype;
      reg_write    = d_reg_write;
      jr           = d_jr;
      muldiv_start = d_muldiv;
      reg_write2   = 1'b0;
      busy         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d      = '0;
            reg_write2 = d_reg_write2;
            busy       = d_muldiv;
         end
         ST_BUSY: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_WB;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WB: begin
            reg_write2 = 1'b1;
            busy       = d_muldiv;
            state_d    = ST_IDLE;
            cnt_d      = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (d_muldiv) begin
         state_d = ST_BUSY;
         op_d    = d_op;
         cnt_d   = d_op[1] ? DIV_LOAD : MULT_LOAD;
      end
      if (rst) begin
         busy         = 1'b0;
         muldiv_start = 1'b0;
         reg_write2   = 1'b0;
      end
   end

   assign muldiv_op = op_q;

endmodule
